// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types and constants for the CPU memory-port arbiter
package cpu_mem_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_e;

    typedef enum logic {IF, DM} arb_owner_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: cycle counter that flags an expired transaction at TIMEOUT_CYC cycles
module arb_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] cnt;

    // count enabled cycles; cleared while the arbiter is idle so each transaction starts at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign expired = en && (cnt == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: round-robin share of one memory port between fetch and data stages (optional watchdog: ARB_TIMEOUT_EN)
module cpu_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        im_stall,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_wstrb,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_stall,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    arb_state_e state, state_n;
    arb_owner_e owner, last_grant;
    logic       discard;
    logic       timeout;

    wire busy      = (state == ISSUE) || (state == WAIT);
    wire grant_if  = if_req && (!dm_req || last_grant == DM);
    wire grant_dm  = dm_req && (!if_req || last_grant == IF);
    wire grant     = (state == IDLE) && (grant_if || grant_dm);
    wire rsp       = ((state == ISSUE) && mem_ready && mem_rvalid) || ((state == WAIT) && mem_rvalid);
    wire fin       = rsp || timeout;
    wire flush_hit = flush && (owner == IF) && busy;
    wire kill_if   = discard || flush_hit;

`ifdef ARB_TIMEOUT_EN
    arb_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == IDLE),
        .en      (busy),
        .expired (timeout)
    );

    // a timeout is recorded until the next reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus_err <= 1'b0;
        else if (timeout)
            bus_err <= 1'b1;
    end
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    // next-state: a simultaneous ready+rvalid or a watchdog expiry skips straight to DONE
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (if_req || dm_req) ? ISSUE : IDLE;
            ISSUE:   state_n = (timeout || (mem_ready && mem_rvalid)) ? DONE : mem_ready ? WAIT : ISSUE;
            WAIT:    state_n = fin ? DONE : WAIT;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // control registers: state, current owner, round-robin history and the fetch-discard flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= IF;
            last_grant <= IF;
            discard    <= 1'b0;
        end else begin
            state <= state_n;
            if (grant)
                owner <= grant_dm ? DM : IF;
            if (state == DONE)
                last_grant <= owner;
            discard <= (state == DONE) ? 1'b0 : (discard || flush_hit);
        end
    end

    // command is latched at grant and held stable until the memory accepts it; rdata captured on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if (grant) begin
                mem_we    <= grant_dm && dm_we;
                mem_wstrb <= grant_dm ? dm_wstrb : 4'b0000;
                mem_addr  <= grant_dm ? dm_addr : if_addr;
                mem_wdata <= grant_dm ? dm_wdata : 32'h0;
            end
            if (fin && owner == IF && !kill_if)
                if_rdata <= timeout ? NOP_INST : mem_rdata;
            if (fin && owner == DM && !mem_we)
                dm_rdata <= timeout ? 32'h0 : mem_rdata;
        end
    end

    assign mem_req  = (state == ISSUE);
    assign im_stall = if_req && !((state == DONE) && (owner == IF) && !discard);
    assign dm_stall = dm_req && !((state == DONE) && (owner == DM));

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed scoreboard bench for cpu_mem_arbiter
module tb_cpu_mem_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic        clk, rst;
    logic        if_req, dm_req, dm_we, flush;
    logic [31:0] if_addr, dm_addr, dm_wdata, if_rdata, dm_rdata;
    logic [3:0]  dm_wstrb, mem_wstrb;
    logic        im_stall, dm_stall, mem_req, mem_we, bus_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready, mem_rvalid;

    cpu_mem_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .im_stall(im_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_wstrb(dm_wstrb), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    typedef struct {
        bit          is_dm;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] issued[$];
    int          vectors = 0;
    int          errors = 0;
    int          cyc = 0;
    int          issue_cyc = 0;
    int          req_cyc = 0;
    int          ready_delay = 0;
    int          rv_delay = 1;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] resp(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0050_0093 : {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input bit is_dm, input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_owner"}, {31'd0, is_dm}, {31'd0, e.is_dm});
        check({tag, "_rdata"}, obs, e.data);
    endtask

    // memory model: ready after ready_delay stalled ISSUE cycles, rvalid rv_delay cycles later
    initial begin
        int          rdy_cnt = 0;
        int          pend = 0;
        bit          busy = 0;
        logic [31:0] pdata = 0, s_addr = 0, s_wdata = 0;
        logic [3:0]  s_strb = 0;
        mem_ready = 0;
        mem_rvalid = 0;
        mem_rdata = 0;
        forever begin
            @(negedge clk);
            mem_ready = 0;
            mem_rvalid = 0;
            if (rst) begin
                rdy_cnt = 0;
                pend = 0;
                busy = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        mem_rvalid = 1;
                        mem_rdata = pdata;
                    end
                end
                if (mem_req) begin
                    if (!busy) begin
                        busy = 1;
                        issue_cyc = cyc;
                        s_addr = mem_addr;
                        s_wdata = mem_wdata;
                        s_strb = mem_wstrb;
                    end else begin
                        check("cmd_addr_stable", mem_addr, s_addr);
                        check("cmd_wdata_stable", mem_wdata, s_wdata);
                        check("cmd_wstrb_stable", {28'd0, mem_wstrb}, {28'd0, s_strb});
                    end
                    if (rdy_cnt >= ready_delay) begin
                        mem_ready = 1;
                        rdy_cnt = 0;
                        busy = 0;
                        issued.push_back(mem_addr);
                        pend = rv_delay;
                        pdata = resp(mem_addr);
                    end else begin
                        rdy_cnt++;
                    end
                end else begin
                    rdy_cnt = 0;
                    busy = 0;
                end
            end
        end
    end

    task automatic do_if(input logic [31:0] addr, input bit do_flush, input logic [31:0] naddr, output int lat);
        int n = 0;
        bit seen = 0, fl = 0;
        @(negedge clk);
        if_req = 1;
        if_addr = addr;
        req_cyc = cyc;
        do begin
            @(negedge clk);
            n++;
            if (do_flush) begin
                flush = 0;
                if (mem_req)
                    seen = 1;
                else if (seen && !fl) begin
                    flush = 1;
                    if_addr = naddr;
                    fl = 1;
                end
            end
        end while (im_stall && n < 200);
        lat = n;
        if (n >= 200)
            check("if_wait_bound", 32'd0, 32'd1);
        else
            pop_check("if", 1'b0, if_rdata);
        if_req = 0;
        flush = 0;
    endtask

    task automatic do_dm(input bit we, input logic [3:0] strb, input logic [31:0] addr, input logic [31:0] wdata, output int lat);
        int n = 0;
        @(negedge clk);
        dm_req = 1;
        dm_we = we;
        dm_wstrb = strb;
        dm_addr = addr;
        dm_wdata = wdata;
        do begin
            @(negedge clk);
            n++;
        end while (dm_stall && n < 200);
        lat = n;
        if (n >= 200)
            check("dm_wait_bound", 32'd0, 32'd1);
        else
            pop_check("dm", 1'b1, dm_rdata);
        dm_req = 0;
        dm_we = 0;
    endtask

    initial begin
        int          l1, l2, n;
        logic [31:0] dm_model;
        rst = 1;
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_wstrb = 0; dm_addr = 0; dm_wdata = 0; flush = 0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_stalls", {30'd0, im_stall, dm_stall}, 32'd0);
        rst = 0;

        // tie after reset: DM first, then IF; a second tie goes to DM again
        issued.delete();
        sb.push_back('{1'b1, resp(32'h208)});
        sb.push_back('{1'b0, resp(32'h104)});
        fork
            do_dm(1'b0, 4'b0000, 32'h208, 32'h0, l1);
            do_if(32'h104, 1'b0, 32'h0, l2);
        join
        sb.push_back('{1'b1, resp(32'h20c)});
        sb.push_back('{1'b0, resp(32'h108)});
        fork
            do_dm(1'b0, 4'b0000, 32'h20c, 32'h0, l1);
            do_if(32'h108, 1'b0, 32'h0, l2);
        join
        dm_model = resp(32'h20c);
        check("rr_order_0", issued.size() > 0 ? issued.pop_front() : 32'hx, 32'h208);
        check("rr_order_1", issued.size() > 0 ? issued.pop_front() : 32'hx, 32'h104);
        check("rr_order_2", issued.size() > 0 ? issued.pop_front() : 32'hx, 32'h20c);
        check("rr_order_3", issued.size() > 0 ? issued.pop_front() : 32'hx, 32'h108);

        // single fetch, minimum latency
        sb.push_back('{1'b0, 32'h0050_0093});
        do_if(32'h100, 1'b0, 32'h0, l1);
        check("if_lat", l1, 32'd3);
        check("if_issue_lat", issue_cyc - req_cyc, 32'd1);

        // write with ready held off 4 cycles; dm_rdata keeps the last load value
        ready_delay = 4;
        sb.push_back('{1'b1, dm_model});
        do_dm(1'b1, 4'b0011, 32'h200, 32'hcafe_f00d, l1);
        ready_delay = 0;
        check("wr_lat", l1, 32'd7);
        check("wr_mem_we", {31'd0, mem_we}, 32'd1);
        check("wr_mem_wstrb", {28'd0, mem_wstrb}, 32'd3);
        check("wr_mem_wdata", mem_wdata, 32'hcafe_f00d);

        // flush in WAIT: first response dropped, refetch from the new address
        rv_delay = 3;
        issued.delete();
        sb.push_back('{1'b0, resp(32'h400)});
        do_if(32'h300, 1'b1, 32'h400, l1);
        rv_delay = 1;
        check("flush_issue_0", issued.size() > 0 ? issued.pop_front() : 32'hx, 32'h300);
        check("flush_issue_1", issued.size() > 0 ? issued.pop_front() : 32'hx, 32'h400);

`ifdef ARB_TIMEOUT_EN
        ready_delay = 1000;
        sb.push_back('{1'b0, 32'h0000_0013});
        do_if(32'h700, 1'b0, 32'h0, l1);
        ready_delay = 0;
        check("to_lat", l1, TO + 1);
        check("to_bus_err", {31'd0, bus_err}, 32'd1);
        sb.push_back('{1'b1, resp(32'h20)});
        do_dm(1'b0, 4'b0000, 32'h20, 32'h0, l1);
        check("to_bus_err_sticky", {31'd0, bus_err}, 32'd1);
`endif

        // reset while waiting for the response
        rv_delay = 20;
        @(negedge clk);
        if_req = 1;
        if_addr = 32'h500;
        n = 0;
        while (!mem_req && n < 50) begin @(negedge clk); n++; end
        while (mem_req && n < 50) begin @(negedge clk); n++; end
        check("rstw_reached_wait", {31'd0, n < 50}, 32'd1);
        rst = 1;
        #1;
        check("rstw_mem_req", {31'd0, mem_req}, 32'd0);
        check("rstw_mem_addr", mem_addr, 32'd0);
        check("rstw_if_rdata", if_rdata, 32'd0);
        check("rstw_bus_err", {31'd0, bus_err}, 32'd0);
        if_req = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        rv_delay = 1;
        sb.push_back('{1'b0, resp(32'h600)});
        do_if(32'h600, 1'b0, 32'h0, l1);
        check("post_rst_lat", l1, 32'd3);
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Shares the CPU's single memory port between instruction fetch (IF) and the data-memory stage (DM), and generates the `im_stall` and `dm_stall` signals that freeze the IF/ID and later pipeline registers. It sits between the CPU core and the memory wrapper. Arbitration is round-robin, so neither requester starves. It supports variable-latency memory, and discards an in-flight fetch when the branch unit flushes.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 64: watchdog limit in cycles; used only under `ARB_TIMEOUT_EN`.

Ports (clock and reset: clk; reset rst, asynchronous, active-high):
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `if_req`  in  1  fetch request, held until `im_stall` is low
- `if_addr`  in  32  fetch address
- `if_rdata`  out  32  fetched instruction, registered
- `im_stall`  out  1  fetch not yet complete
- `dm_req`  in  1  data request, held until `dm_stall` is low
- `dm_we`  in  1  write enable
- `dm_wstrb`  in  4  byte strobes
- `dm_addr`  in  32  data address
- `dm_wdata`  in  32  write data
- `dm_rdata`  out  32  load data, registered
- `dm_stall`  out  1  data access not yet complete
- `flush`  in  1  branch redirect; discard any in-flight fetch
- `mem_req`  out  1  memory command valid
- `mem_we`  out  1  memory write enable
- `mem_wstrb`  out  4  memory byte strobes
- `mem_addr`  out  32  memory address
- `mem_wdata`  out  32  memory write data
- `mem_ready`  in  1  command accepted
- `mem_rvalid`  in  1  response valid; also serves as the write acknowledge
- `mem_rdata`  in  32  response data
- `bus_err`  out  1  sticky timeout flag

## Operation
State machine:
- States: IDLE, ISSUE, WAIT, DONE.
- Registers: `owner` ∈ {IF, DM}, `last_grant`, `discard`.
- IDLE:
  - Only one request pending: grant it.
  - Both pending: grant the requester that is not `last_grant`.
  - On a grant: latch the command into the `mem_*` registers, set `owner`, go to ISSUE.
- ISSUE:
  - `mem_req`=1; command stays stable until `mem_ready`.
  - A request is never withdrawn once issued.
  - On `mem_ready`: go to WAIT.
  - If `mem_ready` and `mem_rvalid` are both high in the same cycle: go straight to DONE.
- WAIT:
  - On `mem_rvalid`: capture `mem_rdata` into the owner's rdata register (writes leave rdata unchanged), go to DONE.
- DONE:
  - The owner's stall is low for exactly this cycle.
  - Set `last_grant`=`owner`, return to IDLE.
  - If `discard`=1: stall is not released, `if_rdata` is not updated, `discard` is cleared.
- Stall outputs:
  - `im_stall` = `if_req` && !(state==DONE && owner==IF && !discard).
  - `dm_stall` = `dm_req` && !(state==DONE && owner==DM).
- Flush:
  - `flush` while owner==IF in ISSUE or WAIT sets `discard`. The bus transaction still completes.
  - After the discarded completion, IF re-arbitrates using the new `if_addr`.
  - `flush` in DONE or IDLE has no effect on the arbiter.
- `mem_rvalid` outside WAIT/ISSUE is ignored.
- Reset:
  - State IDLE; `mem_req`=0; `owner`=IF; `last_grant`=IF, so DM wins the first tie.
  - `discard`=0; `if_rdata`=0; `dm_rdata`=0; `bus_err`=0; all `mem_*` outputs 0.
  - Reset mid-transaction drops `mem_req` immediately. The memory side shares rst.

## Timing
- Grant decision is registered: request at cycle N → `mem_req` at N+1.
- With `mem_ready` at N+1 and `mem_rvalid` at N+2: DONE at N+3, so the stall is low at N+3.
- Minimum stall: 3 cycles.
- rdata is valid from the DONE cycle and holds until the next completion for the same owner.
- Back-to-back: the next grant is evaluated in the IDLE cycle after DONE, giving one idle bus cycle between transactions.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A counter runs in ISSUE/WAIT and clears on entry to ISSUE.
  - At `TIMEOUT_CYC` cycles: force DONE, set `bus_err` (sticky until rst).
  - Return `32'h0000_0013` (NOP) to IF or `32'h0` to DM.
  - A late `mem_rvalid` is ignored.
- Not defined: no counter; `bus_err` tied 0; the arbiter waits indefinitely.

## Structure
- Package `cpu_mem_pkg`:
  - `arb_state_e` (IDLE/ISSUE/WAIT/DONE)
  - `arb_owner_e` (IF/DM)
  - `NOP_INST` = `32'h0000_0013`
- Sub-module `arb_watchdog`: counter with clear, enable, and `TIMEOUT_CYC` compare. Instantiated only under `ARB_TIMEOUT_EN`.

## Test plan
- `if_req` alone at `0x100`, `mem_ready` immediate, `mem_rvalid` 1 cycle later with `0x00500093` → `mem_req` at N+1, `im_stall` low at N+3, `if_rdata`=`0x00500093`.
- `if_req` and `dm_req` together after reset → DM granted first, IF second; third simultaneous request → DM again (alternation).
- DM write `0x200`, `wstrb`=`4'b0011`, `mem_ready` delayed 4 cycles → `mem_addr`/`wdata`/`wstrb` stable across all 4 cycles; `dm_rdata` unchanged.
- `flush` during IF WAIT, new `if_addr`=`0x400` → first response discarded, `im_stall` held; second fetch to `0x400` issued and delivered.
- With `ARB_TIMEOUT_EN`, `TIMEOUT_CYC`=8, no `mem_ready` → DONE after 8 cycles, `if_rdata`=`0x00000013`, `bus_err`=1 until rst.
- rst asserted in WAIT → `mem_req`=0 and state IDLE immediately; after release, a fresh request completes normally.
